seq_mac_reduce: RTL and testbench

SEQ_MAC_REDUCE -- requirements
Module: seq_mac_reduce

---
 rtl/seq_mac_reduce_pkg.sv | 23 ++
 rtl/seq_mac_fsm.sv | 78 +++++++
 rtl/seq_mac_reduce.sv | 114 +++++++++++
 tb/tb_seq_mac_reduce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mac_reduce_pkg.sv
// Shared types, mode encodings and width helpers for the sequential MAC/max reducer.
package seq_mac_reduce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_SUM = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   // Accumulator width: a full product plus headroom so that summing every pair cannot wrap.
   function automatic int unsigned acc_width(input int unsigned width, input int unsigned pairs);
      return 2 * width + ((pairs > 1) ? $clog2(pairs) : 0);
   endfunction

   // Pair index width, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned pairs);
      return (pairs > 1) ? $clog2(pairs) : 1;
   endfunction

endpackage

// File: rtl/seq_mac_fsm.sv
// Job sequencer: IDLE -> ACC (one pair per cycle) -> DONE -> IDLE, with the pair index counter.
module seq_mac_fsm
   import seq_mac_reduce_pkg::*;
#(
   parameter  int unsigned PAIRS = 4,
   localparam int unsigned IDX_W = idx_width(PAIRS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] idx,
   output logic             capture_c,
   output logic             acc_c,
   output logic             last_c
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State, index and status registers; reset aborts any running job immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; busy/done are registered from the next state so they track state_q exactly.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      capture_c = 1'b0;
      acc_c     = 1'b0;
      last_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ACC;
               idx_d     = '0;
               capture_c = 1'b1;
            end
         end
         ACC: begin
            acc_c = 1'b1;
            if (idx_q == IDX_W'(PAIRS - 1)) begin
               last_c  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign idx  = idx_q;

endmodule

// File: rtl/seq_mac_reduce.sv
// Sequential reducer: sum or maximum of PAIRS unsigned products, one pair per cycle.
module seq_mac_reduce
   import seq_mac_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PAIRS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   input  logic [2*PAIRS*WIDTH-1:0] operands,
   output logic [WIDTH-1:0]         result,
   output logic                     overflow,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned OPS_W = 2 * PAIRS * WIDTH;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned ACC_W = acc_width(WIDTH, PAIRS);
   localparam int unsigned IDX_W = idx_width(PAIRS);

   logic [IDX_W-1:0] idx;
   logic             capture_c;
   logic             acc_c;
   logic             last_c;

   logic [OPS_W-1:0] ops_q, ops_d;
   logic             mode_q, mode_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH-1:0] op_a [PAIRS];
   logic [WIDTH-1:0] op_b [PAIRS];
   logic [WIDTH-1:0] a_sel_c;
   logic [WIDTH-1:0] b_sel_c;
   logic [PW-1:0]    prod_c;
   logic [ACC_W-1:0] prod_ext_c;
   logic [ACC_W-1:0] acc_upd_c;

   seq_mac_fsm #(.PAIRS(PAIRS)) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .idx       (idx),
      .capture_c (capture_c),
      .acc_c     (acc_c),
      .last_c    (last_c)
   );

   // Split the captured operand vector into per-pair a/b words.
   for (genvar k = 0; k < PAIRS; k++) begin : g_pair
      assign op_a[k] = ops_q[2*k*WIDTH +: WIDTH];
      assign op_b[k] = ops_q[(2*k+1)*WIDTH +: WIDTH];
   end

   // Combinational multiplier on the current pair and the accumulate/compare step.
   always_comb begin
      a_sel_c    = op_a[idx];
      b_sel_c    = op_b[idx];
      prod_c     = PW'(a_sel_c) * PW'(b_sel_c);
      prod_ext_c = ACC_W'(prod_c);
      if (mode_q == MODE_MAX) begin
         acc_upd_c = (prod_ext_c > acc_q) ? prod_ext_c : acc_q;
      end else begin
         acc_upd_c = acc_q + prod_ext_c;
      end
   end

   // Datapath next-state: capture on start, accumulate in ACC, publish on the last pair.
   always_comb begin
      ops_d      = ops_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      if (capture_c) begin
         ops_d  = operands;
         mode_d = mode;
         acc_d  = '0;
      end else if (acc_c) begin
         acc_d = acc_upd_c;
         if (last_c) begin
            result_d   = acc_upd_c[WIDTH-1:0];
            overflow_d = |acc_upd_c[ACC_W-1:WIDTH];
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_q      <= '0;
         mode_q     <= MODE_SUM;
         acc_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         ops_q      <= ops_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_mac_reduce.sv
// Scoreboard bench for seq_mac_reduce: driver queues expected results, a monitor checks each done pulse.
module tb_seq_mac_reduce;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned PAIRS = 4;
   localparam int unsigned OPS_W = 2 * PAIRS * WIDTH;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             ovf;
      int               cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic [OPS_W-1:0] operands = '0;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             busy;
   logic             done;

   int               cyc = 0;
   int               n_cmp = 0;
   int               n_fail = 0;
   exp_t             q[$];
   logic [WIDTH-1:0] exp_hold = '0;
   logic             exp_hold_ovf = 1'b0;
   logic             done_prev = 1'b0;

   logic [OPS_W-1:0] bb_ops [3];
   logic [WIDTH-1:0] bb_res [3];
   logic             bb_ovf [3];
   int               cap [3];

   seq_mac_reduce #(.WIDTH(WIDTH), .PAIRS(PAIRS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .operands (operands),
      .result   (result),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [OPS_W-1:0] mk4(
      input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1,
      input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] a3, input logic [31:0] b3);
      return {b3, a3, b2, a2, b1, a1, b0, a0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the capture edge.
   task automatic issue_job(input logic m, input logic [OPS_W-1:0] ops,
                            input logic [WIDTH-1:0] er, input logic eo, input bit push);
      chk("idle_before_start", 64'(busy), 64'(0));
      operands = ops;
      mode     = m;
      start    = 1'b1;
      if (push) q.push_back('{res: er, ovf: eo, cyc: cyc + 1 + int'(PAIRS)});
      @(negedge clk);
      start    = 1'b0;
      operands = ~ops;
      chk("busy_after_capture", 64'(busy), 64'(1));
      chk("result_held", 64'(result), 64'(exp_hold));
      chk("overflow_held", 64'(overflow), 64'(exp_hold_ovf));
      if (push) begin
         exp_hold     = er;
         exp_hold_ovf = eo;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   initial begin
      exp_t e;
      bb_ops[0] = mk4(1, 2, 3, 4, 5, 6, 7, 8);
      bb_res[0] = 32'd100;
      bb_ovf[0] = 1'b0;
      bb_ops[1] = mk4(10, 10, 0, 5, 100, 3, 2, 2);
      bb_res[1] = 32'd404;
      bb_ovf[1] = 1'b0;
      bb_ops[2] = mk4(32'h0000FFFF, 32'h0000FFFF, 1, 0, 0, 1, 32'h00010000, 32'h00010000);
      bb_res[2] = 32'hFFFE0001;
      bb_ovf[2] = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (!rst && done) begin
               chk("done_one_cycle", 64'(done_prev), 64'(0));
               if (q.size() == 0) begin
                  chk("unexpected_done", 64'(1), 64'(0));
               end else begin
                  e = q.pop_front();
                  chk("result", 64'(result), 64'(e.res));
                  chk("overflow", 64'(overflow), 64'(e.ovf));
                  chk("done_latency", 64'(cyc), 64'(e.cyc));
               end
            end
            done_prev = done;
         end
      join_none

      // Reset values while rst is held.
      repeat (3) @(negedge clk);
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      rst = 1'b0;

      // Sum of products, launched on the first edge after reset release.
      issue_job(1'b0, mk4(2, 2, 2, 2, 3, 2, 1, 1), 32'd15, 1'b0, 1'b1);
      wait_idle();
      @(negedge clk);

      // Max of products, then an all-zero job.
      issue_job(1'b1, mk4(2, 2, 2, 2, 3, 2, 1, 1), 32'd6, 1'b0, 1'b1);
      wait_idle();
      @(negedge clk);
      issue_job(1'b1, '0, 32'd0, 1'b0, 1'b1);
      wait_idle();
      @(negedge clk);

      // Full-width product overflows the result.
      issue_job(1'b0, mk4(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0), 32'h00000001, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);

      // Max mode with all-ones operands.
      issue_job(1'b1, mk4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 2, 3),
                32'h00000001, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);

      // A start pulse during a running job is ignored.
      issue_job(1'b0, mk4(5, 7, 1, 1, 2, 3, 0, 9), 32'd42, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      start    = 1'b1;
      mode     = 1'b1;
      operands = mk4(9, 9, 9, 9, 9, 9, 9, 9);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("no_pending_after_ignored_start", 64'(q.size()), 64'(0));

      // Start held high: three back-to-back jobs, operands scrambled after each capture.
      for (int j = 0; j < 3; j++) begin
         int n = 0;
         while (busy && n < 64) begin
            @(negedge clk);
            n++;
         end
         if (busy) chk("b2b_timeout", 64'(busy), 64'(0));
         operands = bb_ops[j];
         mode     = 1'b0;
         start    = 1'b1;
         cap[j]   = cyc;
         q.push_back('{res: bb_res[j], ovf: bb_ovf[j], cyc: cyc + 1 + int'(PAIRS)});
         @(negedge clk);
         operands = ~bb_ops[j];
      end
      start = 1'b0;
      chk("b2b_period_1", 64'(cap[1] - cap[0]), 64'(PAIRS + 2));
      chk("b2b_period_2", 64'(cap[2] - cap[1]), 64'(PAIRS + 2));
      wait_idle();
      exp_hold     = bb_res[2];
      exp_hold_ovf = bb_ovf[2];
      @(negedge clk);

      // Reset in the middle of ACC aborts the job asynchronously.
      issue_job(1'b0, mk4(2, 2, 2, 2, 3, 2, 1, 1), 32'd15, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_result", 64'(result), 64'(0));
      chk("abort_overflow", 64'(overflow), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      @(negedge clk);
      rst          = 1'b0;
      exp_hold     = '0;
      exp_hold_ovf = 1'b0;
      issue_job(1'b0, mk4(1, 1, 1, 1, 1, 1, 1, 1), 32'd4, 1'b0, 1'b1);
      wait_idle();
      repeat (4) @(negedge clk);
      chk("no_pending_at_end", 64'(q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
